matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter COMPUTE_CYCLES, default 4: cycles `valid` is held per COMPUTE command (legal range 1..15).
REQ-002 SHALL have parameter FULL_TIMEOUT, default 15: cycles to wait for accumulators after compute (legal range 1..255).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: sequencer accepts a command this cycle.
REQ-007 SHALL have port cmd_op, input, 2: 0=LOAD_W, 1=LOAD_IN, 2=COMPUTE, 3=STORE.
REQ-008 SHALL have port cmd_addr, input, 13: memory/buffer address for the command.
REQ-009 SHALL have port acc1_full and acc2_full, input, 1 each: accumulator-full flags from the datapath.
REQ-010 SHALL have port base_address, output, 13: address driven to weight memory and unified buffer.
REQ-011 SHALL have ports load_weight, load_input, valid and store, output, 1 each: datapath strobes.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a command completes, including errored commands.
REQ-014 SHALL have port err, output, 2: 0=none, 1=compute without weights, 2=accumulator timeout.

Function
REQ-015 SHALL use states IDLE, LOAD_W, LOAD_IN, COMPUTE, WAIT_FULL, STORE, FINISH.
REQ-016 SHALL drive cmd_ready = 1 only in IDLE; a handshake is cmd_valid && cmd_ready on a rising edge.
REQ-017 SHALL, on handshake, register cmd_addr into base_address, clear err, and go to the state selected by cmd_op.
REQ-018 SHALL hold base_address from the handshake until the next handshake.
REQ-019 SHALL assert load_weight for exactly 1 cycle in LOAD_W, set the internal weights_loaded flag, then go to FINISH.
REQ-020 SHALL assert load_input for exactly 1 cycle in LOAD_IN, then go to FINISH.
REQ-021 SHALL, for COMPUTE with weights_loaded = 0, go directly to FINISH with err = 1 and never assert valid.
REQ-022 SHALL, for COMPUTE with weights_loaded = 1, assert valid for exactly COMPUTE_CYCLES consecutive cycles, then go to WAIT_FULL.
REQ-023 SHALL, in WAIT_FULL, go to FINISH once acc1_full && acc2_full is sampled high (both high in the same cycle, or each seen high at some point since WAIT_FULL entry, latched per flag).
REQ-024 SHALL, in WAIT_FULL, set err = 2 and go to FINISH if the flags are not both seen within FULL_TIMEOUT cycles.
REQ-025 SHALL assert store for exactly 1 cycle in STORE, then go to FINISH.
REQ-026 SHALL assert done for 1 cycle in FINISH, then return to IDLE; a command offered during FINISH waits.
REQ-027 SHALL deassert all strobes (load_weight, load_input, valid, store) outside their own states; at most one strobe SHALL be high in any cycle.
REQ-028 SHALL hold err until the next handshake.
REQ-029 SHALL give a command-to-first-strobe latency of 1 cycle: handshake at edge N, strobe high during cycle N+1.
REQ-030 SHALL size the compute counter at 4 bits and the timeout counter at 8 bits, saturating, with no wrap-around.

Reset
REQ-031 SHALL, on reset low, immediately force IDLE, base_address = 0, all strobes = 0, busy = 0, done = 0, err = 0, weights_loaded = 0, and counters = 0, regardless of the current state, including mid-COMPUTE.
REQ-032 SHALL, on reset release, drive cmd_ready = 1 from the first clock edge onward.

Structure
REQ-033 SHALL take the opcode enum, state enum, and err code values from a shared package, tpu_pkg.
REQ-034 SHALL be a single module with no sub-modules; the FSM and the counters are local.

Verification
REQ-035 SHALL cover: reset, then LOAD_W with addr 0x010 -> load_weight high for 1 cycle with base_address = 0x010, done high 2 cycles after the handshake, err = 0.
REQ-036 SHALL cover: COMPUTE directly after reset -> valid never high, done pulses, err = 1.
REQ-037 SHALL cover: LOAD_W, LOAD_IN, COMPUTE, with both full flags raised 2 cycles after valid falls -> valid high for exactly 4 cycles, done 1 cycle after full is seen, err = 0.
REQ-038 SHALL cover: COMPUTE with only acc1_full raised -> err = 2 exactly 15 cycles after WAIT_FULL entry, then done.
REQ-039 SHALL cover: reset asserted in the 2nd valid cycle -> valid drops immediately (asynchronously), and a COMPUTE after release gives err = 1.
REQ-040 SHALL cover: cmd_valid held high across back-to-back STORE commands -> cmd_ready low while busy, exactly one store pulse per command, never two strobes in the same cycle.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: command opcodes, sequencer states and error codes.
package tpu_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_W  = 2'd0,
    OP_LOAD_IN = 2'd1,
    OP_COMPUTE = 2'd2,
    OP_STORE   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_W    = 3'd1,
    S_LOAD_IN   = 3'd2,
    S_COMPUTE   = 3'd3,
    S_WAIT_FULL = 3'd4,
    S_STORE     = 3'd5,
    S_FINISH    = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_NO_WEIGHTS = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd2;

endpackage

// File: rtl/matmul_sequencer.sv
// Matmul command sequencer: accepts one command at a time and walks the
// datapath through load / compute / store, reporting completion and errors.
module matmul_sequencer
  import tpu_pkg::*;
#(
  parameter int COMPUTE_CYCLES = 4,
  parameter int FULL_TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [12:0] cmd_addr,
  input  logic        acc1_full,
  input  logic        acc2_full,
  output logic [12:0] base_address,
  output logic        load_weight,
  output logic        load_input,
  output logic        valid,
  output logic        store,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  localparam logic [3:0] CMP_LAST = 4'(COMPUTE_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(FULL_TIMEOUT - 1);

  state_e      state;
  logic        weights_loaded;
  logic [3:0]  cmp_cnt;
  logic [7:0]  to_cnt;
  logic        seen1, seen2;
  logic        got1, got2;

  // A full flag counts once it has been seen at any point in WAIT_FULL.
  assign got1 = seen1 | acc1_full;
  assign got2 = seen2 | acc2_full;

  // Strobes decode straight from the state register so reset kills them at once.
  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign load_weight = (state == S_LOAD_W);
  assign load_input  = (state == S_LOAD_IN);
  assign valid       = (state == S_COMPUTE);
  assign store       = (state == S_STORE);
  assign done        = (state == S_FINISH);

  // Sequencer FSM with compute and accumulator-timeout counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      base_address   <= '0;
      err            <= ERR_NONE;
      weights_loaded <= 1'b0;
      cmp_cnt        <= '0;
      to_cnt         <= '0;
      seen1          <= 1'b0;
      seen2          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            base_address <= cmd_addr;
            err          <= ERR_NONE;
            cmp_cnt      <= '0;
            to_cnt       <= '0;
            case (op_e'(cmd_op))
              OP_LOAD_W:  state <= S_LOAD_W;
              OP_LOAD_IN: state <= S_LOAD_IN;
              OP_COMPUTE: begin
                if (weights_loaded) state <= S_COMPUTE;
                else begin
                  state <= S_FINISH;
                  err   <= ERR_NO_WEIGHTS;
                end
              end
              default:    state <= S_STORE;
            endcase
          end
        end
        S_LOAD_W: begin
          weights_loaded <= 1'b1;
          state          <= S_FINISH;
        end
        S_LOAD_IN: state <= S_FINISH;
        S_COMPUTE: begin
          if (cmp_cnt >= CMP_LAST) begin
            state  <= S_WAIT_FULL;
            seen1  <= 1'b0;
            seen2  <= 1'b0;
            to_cnt <= '0;
          end else if (cmp_cnt != 4'hF) begin
            cmp_cnt <= cmp_cnt + 4'd1;
          end
        end
        S_WAIT_FULL: begin
          if (got1 && got2) begin
            state <= S_FINISH;
          end else if (to_cnt >= TO_LAST) begin
            err   <= ERR_TIMEOUT;
            state <= S_FINISH;
          end else begin
            seen1 <= got1;
            seen2 <= got2;
            if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
          end
        end
        S_STORE:  state <= S_FINISH;
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: hand-computed strobe timing, error
// codes and handshake behaviour, sampled on the falling edge.
module tb_matmul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [12:0] cmd_addr = 13'd0;
  logic        acc1_full = 1'b0;
  logic        acc2_full = 1'b0;
  logic [12:0] base_address;
  logic        load_weight, load_input, valid, store;
  logic        busy, done;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  int lw_cnt = 0, li_cnt = 0, valid_cnt = 0, store_cnt = 0;
  logic multi_strobe = 1'b0;
  logic rdy_bad = 1'b0;

  matmul_sequencer #(.COMPUTE_CYCLES(4), .FULL_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .acc1_full(acc1_full), .acc2_full(acc2_full),
    .base_address(base_address), .load_weight(load_weight), .load_input(load_input),
    .valid(valid), .store(store), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Running strobe counts plus one-hot and ready/busy consistency tracking.
  always @(negedge clk) begin
    if (reset) begin
      if ((int'(load_weight) + int'(load_input) + int'(valid) + int'(store)) > 1) multi_strobe = 1'b1;
      if (cmd_ready == busy) rdy_bad = 1'b1;
      lw_cnt    += int'(load_weight);
      li_cnt    += int'(load_input);
      valid_cnt += int'(valid);
      store_cnt += int'(store);
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns just after the handshake edge.
  task automatic issue(input logic [1:0] op, input logic [12:0] addr);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("issue_ready_timeout", 16'(cmd_ready), 16'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    int v0, s0, vh;
    logic early;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_base", 16'(base_address), 16'd0);
    chk("rst_strobes", 16'({load_weight, load_input, valid, store}), 16'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", 16'(cmd_ready), 16'd1);

    // COMPUTE without weights
    v0 = valid_cnt;
    issue(2'd2, 13'h020);
    @(negedge clk);
    chk("nw_done", 16'(done), 16'd1);
    chk("nw_err", 16'(err), 16'd1);
    chk("nw_base", 16'(base_address), 16'h020);
    @(negedge clk);
    chk("nw_done_low", 16'(done), 16'd0);
    chk("nw_err_hold", 16'(err), 16'd1);
    chk("nw_ready", 16'(cmd_ready), 16'd1);
    chk("nw_no_valid", 16'(valid_cnt - v0), 16'd0);

    // LOAD_W
    issue(2'd0, 13'h010);
    @(negedge clk);
    chk("lw_strobe", 16'(load_weight), 16'd1);
    chk("lw_base", 16'(base_address), 16'h010);
    chk("lw_err_clr", 16'(err), 16'd0);
    chk("lw_done_early", 16'(done), 16'd0);
    @(negedge clk);
    chk("lw_strobe_low", 16'(load_weight), 16'd0);
    chk("lw_done", 16'(done), 16'd1);
    @(negedge clk);
    chk("lw_done_low", 16'(done), 16'd0);

    // LOAD_IN
    issue(2'd1, 13'h040);
    @(negedge clk);
    chk("li_strobe", 16'(load_input), 16'd1);
    @(negedge clk);
    chk("li_strobe_low", 16'(load_input), 16'd0);
    chk("li_done", 16'(done), 16'd1);
    @(negedge clk);

    // COMPUTE, both flags together two cycles after valid falls
    issue(2'd2, 13'h080);
    vh = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vh += int'(valid);
    end
    chk("cmp_valid_cycles", 16'(vh), 16'd4);
    @(negedge clk);
    chk("cmp_valid_fall", 16'(valid), 16'd0);
    chk("cmp_busy_wait", 16'(busy), 16'd1);
    @(negedge clk);
    chk("cmp_done_early", 16'(done), 16'd0);
    acc1_full = 1'b1;
    acc2_full = 1'b1;
    @(negedge clk);
    chk("cmp_done", 16'(done), 16'd1);
    chk("cmp_err", 16'(err), 16'd0);
    acc1_full = 1'b0;
    acc2_full = 1'b0;
    @(negedge clk);
    chk("cmp_done_low", 16'(done), 16'd0);

    // COMPUTE, flags seen in different cycles
    issue(2'd2, 13'h0C0);
    repeat (5) @(negedge clk);
    acc1_full = 1'b1;
    @(negedge clk);
    acc1_full = 1'b0;
    @(negedge clk);
    chk("latch_done_early", 16'(done), 16'd0);
    acc2_full = 1'b1;
    @(negedge clk);
    chk("latch_done", 16'(done), 16'd1);
    chk("latch_err", 16'(err), 16'd0);
    acc2_full = 1'b0;
    @(negedge clk);

    // COMPUTE with only acc1_full: timeout
    issue(2'd2, 13'h0A0);
    acc1_full = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("to_in_wait", 16'(valid), 16'd0);
    early = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (done || err != 2'd0) early = 1'b1;
    end
    chk("to_not_early", 16'(early), 16'd0);
    @(negedge clk);
    chk("to_err", 16'(err), 16'd2);
    chk("to_done", 16'(done), 16'd1);
    @(negedge clk);
    chk("to_done_low", 16'(done), 16'd0);
    chk("to_err_hold", 16'(err), 16'd2);
    acc1_full = 1'b0;

    // Reset in the 2nd valid cycle
    issue(2'd2, 13'h0B0);
    @(negedge clk);
    chk("mr_valid1", 16'(valid), 16'd1);
    @(negedge clk);
    chk("mr_valid2", 16'(valid), 16'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr_valid_drop", 16'(valid), 16'd0);
    chk("mr_busy", 16'(busy), 16'd0);
    chk("mr_base", 16'(base_address), 16'd0);
    chk("mr_err", 16'(err), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    v0 = valid_cnt;
    issue(2'd2, 13'h0B0);
    @(negedge clk);
    chk("mr_nw_err", 16'(err), 16'd1);
    chk("mr_nw_done", 16'(done), 16'd1);
    @(negedge clk);
    chk("mr_no_valid", 16'(valid_cnt - v0), 16'd0);

    // Back-to-back STOREs with cmd_valid held high
    s0 = store_cnt;
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_addr  = 13'h100;
    repeat (9) @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("st_pulses", 16'(store_cnt - s0), 16'd3);
    chk("st_base", 16'(base_address), 16'h100);
    chk("one_hot_strobes", 16'(multi_strobe), 16'd0);
    chk("ready_vs_busy", 16'(rdy_bad), 16'd0);
    chk("lw_total", 16'(lw_cnt), 16'd1);
    chk("li_total", 16'(li_cnt), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
